brute_force_scheduler: RTL

//  Sequencing controller for one brute-force password search engine (ASCII counter chain plus comparator).

---
 rtl/brute_force_scheduler.sv | 122 ++++++++++++
 1 files changed

// File: rtl/brute_force_scheduler.sv
// Sequencer for one brute-force password engine: sweeps word lengths, gates the engine
// and tracks comparator results through a MATCH_LATENCY-deep candidate pipeline.
module brute_force_scheduler #(
    parameter int MATCH_LATENCY = 2,
    parameter int MAX_WORD_LEN  = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic         abort,
    input  logic [4:0]   cfgMaxLength,
    input  logic [2:0]   cfgStartPos,
    input  logic [2:0]   cfgIncrement,
    input  logic [127:0] engPassword,
    input  logic         engWrap,
    input  logic         matchValid,
    input  logic         matchHit,
    output logic         engEnable,
    output logic         engClear,
    output logic [2:0]   startingPosition,
    output logic [2:0]   increment,
    output logic [7:0]   wordLength,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [127:0] password,
    output logic [31:0]  cycleCount
);
    localparam int DW = (MATCH_LATENCY > 1) ? $clog2(MATCH_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [MATCH_LATENCY-1:0][127:0] pipe_q;
    logic [DW-1:0]                   drain_q;
    logic [4:0]                      maxLen_q;
    logic                            cfg_ok, active, accept, hit, drain_end;

    always_comb begin
        cfg_ok    = (cfgMaxLength != 5'd0) && (cfgMaxLength <= 5'(MAX_WORD_LEN)) &&
                    (cfgIncrement != 3'd0);
        active    = (state_q == LOAD) || (state_q == RUN) || (state_q == DRAIN);
        accept    = ((state_q == IDLE) || (state_q == DONE)) && start && !abort;
        hit       = matchValid && matchHit && ((state_q == RUN) || (state_q == DRAIN));
        drain_end = (state_q == DRAIN) && (drain_q == '0);
        state_d   = state_q;
        case (state_q)
            IDLE, DONE: if (accept) state_d = cfg_ok ? LOAD : DONE;
            LOAD:       state_d = RUN;
            RUN: begin
                if (hit)          state_d = DONE;
                else if (engWrap) state_d = DRAIN;
            end
            DRAIN: begin
                if (hit)            state_d = DONE;
                else if (drain_end) state_d = (wordLength == {3'b000, maxLen_q}) ? DONE : LOAD;
            end
            default:    state_d = IDLE;
        endcase
        if (active && abort) state_d = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            pipe_q           <= '0;
            drain_q          <= '0;
            maxLen_q         <= '0;
            engEnable        <= 1'b0;
            engClear         <= 1'b0;
            startingPosition <= '0;
            increment        <= '0;
            wordLength       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            found            <= 1'b0;
            password         <= '0;
            cycleCount       <= '0;
        end else begin
            state_q   <= state_d;
            engEnable <= (state_d == RUN);
            engClear  <= (state_d == LOAD);
            busy      <= (state_d == LOAD) || (state_d == RUN) || (state_d == DRAIN);
            done      <= (state_d == DONE);

            // Keep shifting through DRAIN so the tail lines up with late results.
            if ((state_q == RUN) || (state_q == DRAIN)) begin
                pipe_q[0] <= engPassword;
                for (int i = 1; i < MATCH_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            end

            if (state_q == RUN)
                drain_q <= DW'(MATCH_LATENCY - 1);
            else if ((state_q == DRAIN) && (drain_q != '0))
                drain_q <= drain_q - 1'b1;

            if (active && (cycleCount != '1)) cycleCount <= cycleCount + 32'd1;

            if (accept) begin
                found      <= 1'b0;
                password   <= '0;
                cycleCount <= '0;
                if (cfg_ok) begin
                    startingPosition <= cfgStartPos;
                    increment        <= cfgIncrement;
                    maxLen_q         <= cfgMaxLength;
                    wordLength       <= 8'd1;
                end
            end

            if (active && abort) begin
                found    <= 1'b0;
                password <= '0;
            end else if (hit) begin
                found    <= 1'b1;
                password <= pipe_q[MATCH_LATENCY-1];
            end else if (drain_end && (state_d == LOAD)) begin
                wordLength <= wordLength + 8'd1;
            end
        end
    end
endmodule
